meh16_datapath: RTL and testbench

Register-and-bus datapath for the MEH16 CPU, directly downstream of the microcoded controller. Each cycle it takes the controller's 13-bit control word, `alu_op` and `a_op`, and moves data over a single shared 16-bit bus between registers A, B, PC, MAR, IR, the ALU and the external RAM. It also holds the Z/C/S flags register and returns `ir_opcode`, `ram_opcode`, `ram_arg` and `flags` to the controller.

---
 rtl/meh16_pkg.sv | 50 +++++
 rtl/meh16_alu.sv | 35 +++
 rtl/meh16_datapath.sv | 115 +++++++++++
 tb/tb_meh16_datapath.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meh16_pkg.sv
// Shared MEH16 definitions: control-word bit positions, ALU/A-unit encodings,
// flag bit positions and the instruction opcode map used by the controller.
package meh16_pkg;

  localparam int MEH_DATA_W = 16;
  localparam int MEH_ADDR_W = 12;
  localparam int CTL_W      = 13;

  localparam int CTL_ALU_EN   = 12;
  localparam int CTL_RAM_EN   = 11;
  localparam int CTL_MAR_LOAD = 10;
  localparam int CTL_RAM_LOAD = 9;
  localparam int CTL_A_EN     = 8;
  localparam int CTL_A_LOAD   = 7;
  localparam int CTL_B_EN     = 6;
  localparam int CTL_B_LOAD   = 5;
  localparam int CTL_PC_EN    = 4;
  localparam int CTL_PC_LOAD  = 3;
  localparam int CTL_PC_INC   = 2;
  localparam int CTL_IR_EN    = 1;
  localparam int CTL_IR_LOAD  = 0;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBB, ALU_MOD, ALU_AND, ALU_OR, ALU_XOR
  } alu_op_e;

  typedef enum logic [2:0] {
    AOP_NONE, AOP_INC, AOP_DEC, AOP_SHL, AOP_SHR, AOP_NOT, AOP_COM, AOP_RSVD
  } a_op_e;

  typedef enum logic [3:0] {
    OPC_NOARG, OPC_LDA, OPC_LDB, OPC_STA, OPC_ADD, OPC_ADDC, OPC_SUB, OPC_SUBB,
    OPC_MOD, OPC_AND, OPC_OR, OPC_XOR, OPC_JMP, OPC_JZ, OPC_JC, OPC_JS
  } opcode_e;

  typedef enum logic [3:0] {
    NA_NOP, NA_HLT, NA_INC, NA_DEC, NA_SHL, NA_SHR, NA_NOT, NA_COM
  } noarg_op_e;

  // True when two or more bus drivers are enabled in the same control word.
  function automatic logic multi_driver(input logic [CTL_W-1:0] c);
    return $countones({c[CTL_ALU_EN], c[CTL_RAM_EN], c[CTL_A_EN],
                       c[CTL_B_EN], c[CTL_PC_EN], c[CTL_IR_EN]}) > 1;
  endfunction

endpackage

// File: rtl/meh16_alu.sv
// Combinational MEH16 ALU: add/sub with carry or borrow, modulo, bitwise ops.
module meh16_alu
  import meh16_pkg::*;
#(
  parameter int DATA_W = MEH_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] wide;

  // The extra top bit carries out of ADD/ADDC and reads as borrow for SUB/SUBB.
  always_comb begin
    wide = '0;
    case (op)
      ALU_ADD:  wide = {1'b0, a} + {1'b0, b};
      ALU_ADDC: wide = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
      ALU_SUB:  wide = {1'b0, a} - {1'b0, b};
      ALU_SUBB: wide = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
      ALU_MOD:  wide = {1'b0, (b == '0) ? a : (a % b)};
      ALU_AND:  wide = {1'b0, a & b};
      ALU_OR:   wide = {1'b0, a | b};
      ALU_XOR:  wide = {1'b0, a ^ b};
      default:  wide = '0;
    endcase
    result = wide[DATA_W-1:0];
    carry  = wide[DATA_W];
  end

endmodule

// File: rtl/meh16_datapath.sv
// MEH16 register/bus datapath: one shared bus between A, B, PC, MAR, IR, the
// ALU and RAM, plus the Z/C/S flags and a sticky bus-conflict indicator.
module meh16_datapath
  import meh16_pkg::*;
#(
  parameter int DATA_W = MEH_DATA_W,
  parameter int ADDR_W = MEH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTL_W-1:0]  ctrl,
  input  logic [2:0]        alu_op,
  input  logic [2:0]        a_op,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [3:0]        ram_opcode,
  output logic [ADDR_W-1:0] ram_arg,
  output logic [3:0]        ir_opcode,
  output logic [2:0]        flags,
  output logic              bus_conflict
);

  localparam int HI_W = DATA_W - ADDR_W;

  logic [DATA_W-1:0] a_reg, b_reg, ir_reg;
  logic [ADDR_W-1:0] pc_reg, mar_reg;
  logic [2:0]        flag_reg;
  logic              conflict_reg;

  logic [DATA_W-1:0] bus, alu_res, aop_new;
  logic [DATA_W:0]   aop_res;
  logic              alu_c, aop_eff;

  // In-place A rewrite; returns {carry, new A}.
  function automatic logic [DATA_W:0] a_unit(input logic [DATA_W-1:0] a, input a_op_e op);
    logic signed [DATA_W-1:0] a_s;
    a_s = signed'(a);
    case (op)
      AOP_INC: return {a == '1, a + DATA_W'(1)};
      AOP_DEC: return {a == '0, a - DATA_W'(1)};
      AOP_SHL: return {a[DATA_W-1], a << 1};
      AOP_SHR: return {a[0], a >> 1};
      AOP_NOT: return {1'b0, ~a};
      AOP_COM: return {1'b0, -a_s};
      default: return {1'b0, a};
    endcase
  endfunction

  function automatic logic [2:0] mk_flags(input logic [DATA_W-1:0] r, input logic c);
    logic [2:0] f;
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_S] = r[DATA_W-1];
    return f;
  endfunction

  meh16_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .cin    (flag_reg[FLAG_C]),
    .op     (alu_op_e'(alu_op)),
    .result (alu_res),
    .carry  (alu_c)
  );

  assign aop_res = a_unit(a_reg, a_op_e'(a_op));
  assign aop_new = aop_res[DATA_W-1:0];
  // A_LOAD overrides the A unit, including its flag write.
  assign aop_eff = (a_op != AOP_NONE) && (a_op != AOP_RSVD) && !ctrl[CTL_A_LOAD];

  always_comb begin
    if      (ctrl[CTL_ALU_EN]) bus = alu_res;
    else if (ctrl[CTL_RAM_EN]) bus = ram_rdata;
    else if (ctrl[CTL_A_EN])   bus = a_reg;
    else if (ctrl[CTL_B_EN])   bus = b_reg;
    else if (ctrl[CTL_PC_EN])  bus = {{HI_W{1'b0}}, pc_reg};
    else if (ctrl[CTL_IR_EN])  bus = {{HI_W{1'b0}}, ir_reg[ADDR_W-1:0]};
    else                       bus = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      ir_reg       <= '0;
      pc_reg       <= '0;
      mar_reg      <= '0;
      flag_reg     <= '0;
      conflict_reg <= 1'b0;
    end else begin
      if (ctrl[CTL_A_LOAD])   a_reg <= bus;
      else if (aop_eff)       a_reg <= aop_new;
      if (ctrl[CTL_B_LOAD])   b_reg <= bus;
      if (ctrl[CTL_IR_LOAD])  ir_reg <= bus;
      if (ctrl[CTL_MAR_LOAD]) mar_reg <= bus[ADDR_W-1:0];
      if (ctrl[CTL_PC_LOAD])  pc_reg <= bus[ADDR_W-1:0];
      else if (ctrl[CTL_PC_INC]) pc_reg <= pc_reg + ADDR_W'(1);
      if (ctrl[CTL_ALU_EN] && ctrl[CTL_A_LOAD]) flag_reg <= mk_flags(alu_res, alu_c);
      else if (aop_eff)                         flag_reg <= mk_flags(aop_new, aop_res[DATA_W]);
      if (multi_driver(ctrl)) conflict_reg <= 1'b1;
    end
  end

  assign ram_addr     = mar_reg;
  assign ram_wdata    = bus;
  assign ram_we       = ctrl[CTL_RAM_LOAD];
  assign ram_opcode   = ram_rdata[DATA_W-1 -: 4];
  assign ram_arg      = ram_rdata[ADDR_W-1:0];
  assign ir_opcode    = ir_reg[DATA_W-1 -: 4];
  assign flags        = flag_reg;
  assign bus_conflict = conflict_reg;

endmodule

// File: tb/tb_meh16_datapath.sv
// Scoreboard bench for meh16_datapath: directed scenarios plus random control
// words, checked against an arithmetic reference model of the datapath.
module tb_meh16_datapath;

  localparam logic [12:0] ALU_EN = 13'h1000, RAM_EN = 13'h0800, MAR_LD = 13'h0400,
                          RAM_LD = 13'h0200, A_EN   = 13'h0100, A_LD   = 13'h0080,
                          B_EN   = 13'h0040, B_LD   = 13'h0020, PC_EN  = 13'h0010,
                          PC_LD  = 13'h0008, PC_INC = 13'h0004, IR_EN  = 13'h0002,
                          IR_LD  = 13'h0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] ctrl = '0;
  logic [2:0]  alu_op = '0, a_op = '0;
  logic [15:0] ram_rdata = '0;
  logic [11:0] ram_addr, ram_arg;
  logic [15:0] ram_wdata;
  logic        ram_we, bus_conflict;
  logic [3:0]  ram_opcode, ir_opcode;
  logic [2:0]  flags;

  meh16_datapath dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .alu_op(alu_op), .a_op(a_op),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_opcode(ram_opcode), .ram_arg(ram_arg),
    .ir_opcode(ir_opcode), .flags(flags), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bus;
    logic [2:0]  flags;
    logic [11:0] mar;
    logic [3:0]  irop;
    logic        conf;
    logic        we;
    logic [3:0]  rop;
    logic [11:0] rarg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0, n_fail = 0;
  bit   obs_vld = 1'b0;

  // Reference state
  int unsigned mA, mB, mPC, mMAR, mIR;
  bit mZ, mC, mS, mconf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    n_vec++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exv);
    end
  endtask

  function automatic void model_reset();
    mA = 0; mB = 0; mPC = 0; mMAR = 0; mIR = 0;
    mZ = 0; mC = 0; mS = 0; mconf = 0;
  endfunction

  function automatic void alu_ref(input int unsigned op, output int unsigned r, output bit c);
    int s;
    s = 0; c = 0;
    case (op)
      0: begin s = int'(mA) + int'(mB);           c = (s > 65535); end
      1: begin s = int'(mA) + int'(mB) + int'(mC); c = (s > 65535); end
      2: begin s = int'(mA) - int'(mB);           c = (s < 0); end
      3: begin s = int'(mA) - int'(mB) - int'(mC); c = (s < 0); end
      4: s = (mB == 0) ? int'(mA) : int'(mA % mB);
      5: s = int'(mA & mB);
      6: s = int'(mA | mB);
      default: s = int'(mA ^ mB);
    endcase
    r = s & 32'hFFFF;
  endfunction

  function automatic int unsigned bus_ref(input logic [12:0] c, input int unsigned rd,
                                          input int unsigned alu_r);
    if (c[12]) return alu_r;
    if (c[11]) return rd;
    if (c[8])  return mA;
    if (c[6])  return mB;
    if (c[4])  return mPC;
    if (c[1])  return mIR % 4096;
    return 0;
  endfunction

  function automatic exp_t exp_now(input logic [12:0] c, input int unsigned aluop,
                                   input int unsigned rd);
    exp_t e;
    int unsigned ar;
    bit ac;
    alu_ref(aluop, ar, ac);
    e.bus   = 16'(bus_ref(c, rd, ar));
    e.flags = {mS, mC, mZ};
    e.mar   = 12'(mMAR);
    e.irop  = 4'(mIR / 4096);
    e.conf  = mconf;
    e.we    = c[9];
    e.rop   = 4'(rd / 4096);
    e.rarg  = 12'(rd % 4096);
    return e;
  endfunction

  function automatic void set_flags(input int unsigned r, input bit c);
    mZ = (r == 0); mS = (r >= 32768); mC = c;
  endfunction

  function automatic void model_step(input logic [12:0] c, input int unsigned aluop,
                                     input int unsigned aop, input int unsigned rd);
    int unsigned ar, bus, na;
    bit ac, nc;
    int drivers;
    alu_ref(aluop, ar, ac);
    bus = bus_ref(c, rd, ar);
    drivers = int'(c[12]) + int'(c[11]) + int'(c[8]) + int'(c[6]) + int'(c[4]) + int'(c[1]);
    na = mA; nc = 0;
    case (aop)
      1: begin na = (mA + 1) % 65536;     nc = (mA == 65535); end
      2: begin na = (mA + 65535) % 65536; nc = (mA == 0); end
      3: begin na = (mA * 2) % 65536;     nc = (mA >= 32768); end
      4: begin na = mA / 2;               nc = ((mA % 2) == 1); end
      5: begin na = 65535 - mA;           nc = 0; end
      6: begin na = (65536 - mA) % 65536; nc = 0; end
      default: ;
    endcase
    if (c[7]) begin
      if (c[12]) set_flags(ar, ac);
      mA = bus;
    end else if (aop >= 1 && aop <= 6) begin
      set_flags(na, nc);
      mA = na;
    end
    if (c[5])  mB = bus;
    if (c[0])  mIR = bus;
    if (c[10]) mMAR = bus % 4096;
    if (c[3])  mPC = bus % 4096;
    else if (c[2]) mPC = (mPC + 1) % 4096;
    if (drivers >= 2) mconf = 1;
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic cycle(input logic [12:0] c, input int unsigned aluop,
                       input int unsigned aop, input int unsigned rd);
    ctrl = c; alu_op = 3'(aluop); a_op = 3'(aop); ram_rdata = 16'(rd);
    exp_q.push_back(exp_now(c, aluop, rd));
    obs_vld = 1'b1;
    model_step(c, aluop, aop, rd);
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [12:0] c, input int unsigned v, input string nm);
    ctrl = c; alu_op = '0; a_op = '0; ram_rdata = '0;
    #2;
    chk(nm, 32'(ram_wdata), v);
    cycle(c, 0, 0, 0);
  endtask

  task automatic do_reset_check();
    ctrl = A_EN; alu_op = '0; a_op = '0; ram_rdata = '0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_a", 32'(ram_wdata), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_conflict", 32'(bus_conflict), 0);
    chk("rst_mar", 32'(ram_addr), 0);
    exp_q.push_back(exp_now(A_EN, 0, 0));
    obs_vld = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      ctrl = (k == 0) ? B_EN : (k == 1) ? PC_EN : IR_EN;
      exp_q.push_back(exp_now(ctrl, 0, 0));
      @(posedge clk); #1;
    end
    obs_vld = 1'b0;
    ctrl = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic int drv_bit(input int k);
    case (k)
      0: return 12;
      1: return 11;
      2: return 8;
      3: return 6;
      4: return 4;
      default: return 1;
    endcase
  endfunction

  task automatic rand_cycle();
    logic [12:0] c;
    int unsigned rd;
    int k;
    c = 13'($urandom) & 13'h06AD;
    k = $urandom_range(0, 6);
    if (k < 6) c[drv_bit(k)] = 1'b1;
    if ($urandom_range(0, 59) == 0) c[drv_bit($urandom_range(0, 5))] = 1'b1;
    case ($urandom_range(0, 7))
      0: rd = 0;
      1: rd = 16'hFFFF;
      2: rd = 16'h8000;
      3: rd = 1;
      default: rd = $urandom_range(0, 65535);
    endcase
    cycle(c, $urandom_range(0, 7), $urandom_range(0, 7), rd);
  endtask

  // Monitor: pops one expectation per observed cycle, away from the rising edge.
  always @(negedge clk) begin
    if (obs_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue, expected an entry", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bus",          32'(ram_wdata),    32'(mon_e.bus));
        chk("flags",        32'(flags),        32'(mon_e.flags));
        chk("ram_addr",     32'(ram_addr),     32'(mon_e.mar));
        chk("ir_opcode",    32'(ir_opcode),    32'(mon_e.irop));
        chk("bus_conflict", 32'(bus_conflict), 32'(mon_e.conf));
        chk("ram_we",       32'(ram_we),       32'(mon_e.we));
        chk("ram_opcode",   32'(ram_opcode),   32'(mon_e.rop));
        chk("ram_arg",      32'(ram_arg),      32'(mon_e.rarg));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got no finish, expected completion", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-instruction with A holding data
    cycle(RAM_EN | A_LD, 0, 0, 16'h1234);
    do_reset_check();

    // Fetch with jump
    cycle(RAM_EN | PC_LD, 0, 0, 16'h0005);
    cycle(RAM_EN | PC_LD | IR_LD, 0, 0, 16'hC0A0);
    chk("jump_ir_opcode", 32'(ir_opcode), 32'hC);
    peek(PC_EN, 16'h00A0, "jump_pc");
    peek(IR_EN, 16'h00A0, "jump_ir_low");

    // ADD with carry out, then ADDC consuming it
    cycle(RAM_EN | A_LD, 0, 0, 16'hFFFF);
    cycle(RAM_EN | B_LD, 0, 0, 16'h0001);
    cycle(ALU_EN | A_LD, 0, 0, 0);
    chk("add_flags", 32'(flags), 32'b011);
    peek(A_EN, 16'h0000, "add_a");
    cycle(RAM_EN | A_LD, 0, 0, 16'h0001);
    cycle(RAM_EN | B_LD, 0, 0, 16'h0001);
    cycle(ALU_EN | A_LD, 1, 0, 0);
    peek(A_EN, 16'h0003, "addc_a");

    // SUB with borrow, then MOD by zero
    cycle(RAM_EN | B_LD, 0, 0, 16'h0005);
    cycle(ALU_EN | A_LD, 2, 0, 0);
    chk("sub_flags", 32'(flags), 32'b110);
    peek(A_EN, 16'hFFFE, "sub_a");
    cycle(RAM_EN | B_LD, 0, 0, 16'h0000);
    cycle(ALU_EN | A_LD, 4, 0, 0);
    chk("mod0_flags", 32'(flags), 32'b100);
    peek(A_EN, 16'hFFFE, "mod0_a");

    // Shift left through carry, PC wrap, A_LOAD beating a_op
    cycle(RAM_EN | A_LD, 0, 0, 16'h8001);
    cycle('0, 0, 3, 0);
    chk("shl_flags", 32'(flags), 32'b010);
    peek(A_EN, 16'h0002, "shl_a");
    cycle(RAM_EN | PC_LD, 0, 0, 16'h0FFF);
    cycle(PC_INC, 0, 0, 0);
    peek(PC_EN, 16'h0000, "pc_wrap");
    cycle(RAM_EN | A_LD, 0, 1, 16'h0042);
    chk("aload_wins_flags", 32'(flags), 32'b010);
    peek(A_EN, 16'h0042, "aload_wins_a");

    // Bus conflict: A has priority, flag is sticky until reset
    cycle(RAM_EN | A_LD, 0, 0, 16'h0ABC);
    cycle(RAM_EN | B_LD, 0, 0, 16'h0123);
    cycle(A_EN | B_EN | MAR_LD, 0, 0, 0);
    chk("conflict_mar", 32'(ram_addr), 32'hABC);
    chk("conflict_set", 32'(bus_conflict), 1);
    repeat (3) cycle('0, 0, 0, 0);
    chk("conflict_sticky", 32'(bus_conflict), 1);
    do_reset_check();

    // Random control words
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 250; i++) begin
        rand_cycle();
        if (i % 10 == 9) begin
          cycle(A_EN, 0, 0, 0);
          cycle(B_EN, 0, 0, 0);
          cycle(PC_EN, 0, 0, 0);
          cycle(IR_EN, 0, 0, 0);
        end
      end
      do_reset_check();
    end

    obs_vld = 1'b0;
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
